// File: rtl/winograd_sched.sv
// rtl/winograd_sched.sv - Winograd job controller: credit-gated tile issue, channel accumulation, output FIFO
module winograd_sched #(
    parameter int IN_SIZE_0  = 4,
    parameter int IN_SIZE_1  = 8,
    parameter int DP_SIZE    = ((IN_SIZE_1 + 1) * 2) + 6,
    parameter int ACC_SIZE   = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [CNT_WIDTH-1:0] num_tiles_i,
    input  logic [CNT_WIDTH-1:0] num_ch_i,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [IN_SIZE_0-1:0] in_0_i [0:7],
    input  logic [IN_SIZE_1-1:0] in_1_i [0:7],
    output logic [IN_SIZE_0-1:0] dp_in_0_o [0:7],
    output logic [IN_SIZE_1-1:0] dp_in_1_o [0:7],
    input  logic [DP_SIZE-1:0]   dp_out_i [0:1],
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ACC_SIZE-1:0]  out_data_o [0:1],
    output logic                 out_last_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    typedef struct packed {
        logic valid;
        logic first_ch;
        logic last_ch;
        logic last_tile;
    } tag_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] num_tiles_q, num_ch_q, tile_cnt, ch_cnt;
    tag_t                 tag_q [0:1];
    logic [ACC_SIZE-1:0]  acc_q [0:1];
    logic [ACC_SIZE-1:0]  sum [0:1];
    logic [ACC_SIZE-1:0]  fifo_data [0:FIFO_DEPTH-1][0:1];
    logic                 fifo_last [0:FIFO_DEPTH-1];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        fifo_count, fifo_count_nxt;
    logic [1:0]           inflight_lc;
    logic [CW:0]          credit_used;
    logic                 issue, push, pop, ch_wrap, tile_last, final_issue, drain_done;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Every in-flight last_ch tag already owns a FIFO slot, so issue stops before the FIFO can overflow.
    assign inflight_lc = {1'b0, tag_q[0].valid && tag_q[0].last_ch}
                       + {1'b0, tag_q[1].valid && tag_q[1].last_ch};
    assign credit_used = {1'b0, fifo_count} + (CW + 1)'(inflight_lc);
    assign in_ready_o  = (state == S_RUN) && (credit_used < (CW + 1)'(FIFO_DEPTH));
    assign issue       = in_valid_i && in_ready_o;

    assign ch_wrap     = (ch_cnt == num_ch_q - CNT_WIDTH'(1));
    assign tile_last   = (tile_cnt == num_tiles_q - CNT_WIDTH'(1));
    assign final_issue = issue && ch_wrap && tile_last;

    assign push        = tag_q[1].valid && tag_q[1].last_ch;
    assign out_valid_o = (fifo_count != '0);
    assign pop         = out_valid_o && out_ready_i;
    assign out_last_o  = out_valid_o && fifo_last[rd_ptr];
    assign drain_done  = !tag_q[0].valid && (fifo_count_nxt == '0);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            dp_in_0_o[i] = issue ? in_0_i[i] : '0;
            dp_in_1_o[i] = issue ? in_1_i[i] : '0;
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            sum[k]        = (tag_q[1].first_ch ? '0 : acc_q[k]) + ACC_SIZE'($signed(dp_out_i[k]));
            out_data_o[k] = out_valid_o ? fifo_data[rd_ptr][k] : '0;
        end
    end

    always_comb begin
        fifo_count_nxt = fifo_count;
        if (push && !pop) begin
            fifo_count_nxt = fifo_count + CW'(1);
        end else if (pop && !push) begin
            fifo_count_nxt = fifo_count - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            num_tiles_q <= '0;
            num_ch_q    <= '0;
            tile_cnt    <= '0;
            ch_cnt      <= '0;
            tag_q[0]    <= '0;
            tag_q[1]    <= '0;
            acc_q[0]    <= '0;
            acc_q[1]    <= '0;
        end else begin
            tag_q[0] <= issue ? {1'b1, ch_cnt == '0, ch_wrap, tile_last} : 4'b0;
            tag_q[1] <= tag_q[0];
            if (tag_q[1].valid) begin
                acc_q[0] <= sum[0];
                acc_q[1] <= sum[1];
            end
            if (issue) begin
                if (ch_wrap) begin
                    ch_cnt   <= '0;
                    tile_cnt <= tile_cnt + CNT_WIDTH'(1);
                end else begin
                    ch_cnt <= ch_cnt + CNT_WIDTH'(1);
                end
            end
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        num_tiles_q <= num_tiles_i;
                        num_ch_q    <= num_ch_i;
                        tile_cnt    <= '0;
                        ch_cnt      <= '0;
                        if (num_tiles_i != '0 && num_ch_i != '0) begin
                            state  <= S_RUN;
                            busy_o <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (final_issue) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_done) begin
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_o <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fifo_count <= fifo_count_nxt;
            assert (!(push && !pop && (fifo_count == CW'(FIFO_DEPTH))));
        end
    end

    // Storage needs no reset: out_valid_o gates every read of it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[wr_ptr][0] <= sum[0];
            fifo_data[wr_ptr][1] <= sum[1];
            fifo_last[wr_ptr]    <= tag_q[1].last_tile;
        end
    end

endmodule

// File: tb/tb_winograd_sched.sv
// tb/tb_winograd_sched.sv - self-checking bench for winograd_sched with a 2-cycle scripted datapath model
module tb_winograd_sched;
    localparam int IN0   = 4;
    localparam int IN1   = 8;
    localparam int DPW   = ((IN1 + 1) * 2) + 6;
    localparam int ACCW  = 32;
    localparam int DEPTH = 4;
    localparam int CNTW  = 8;

    typedef struct { logic [DPW-1:0] r0; logic [DPW-1:0] r1; } res_t;
    typedef struct { logic [ACCW-1:0] d0; logic [ACCW-1:0] d1; logic last; } out_t;
    typedef struct { int ch; logic [DPW-1:0] a; logic [DPW-1:0] b; logic [ACCW-1:0] e0; logic [ACCW-1:0] e1; } vec_t;

    logic            clk_i = 1'b0;
    logic            rst_i, start_i, in_valid_i, out_ready_i;
    logic [CNTW-1:0] num_tiles_i, num_ch_i;
    logic            busy_o, done_o, in_ready_o, out_valid_o, out_last_o;
    logic [IN0-1:0]  in_0_i [0:7];
    logic [IN1-1:0]  in_1_i [0:7];
    logic [IN0-1:0]  dp_in_0_o [0:7];
    logic [IN1-1:0]  dp_in_1_o [0:7];
    logic [DPW-1:0]  dp_out_i [0:1];
    logic [ACCW-1:0] out_data_o [0:1];

    winograd_sched #(
        .IN_SIZE_0(IN0), .IN_SIZE_1(IN1), .DP_SIZE(DPW),
        .ACC_SIZE(ACCW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CNTW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .num_tiles_i(num_tiles_i), .num_ch_i(num_ch_i),
        .busy_o(busy_o), .done_o(done_o),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_0_i(in_0_i), .in_1_i(in_1_i),
        .dp_in_0_o(dp_in_0_o), .dp_in_1_o(dp_in_1_o),
        .dp_out_i(dp_out_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_last_o(out_last_o)
    );

    always #5 clk_i = ~clk_i;

    int   checks = 0;
    int   errors = 0;
    res_t scr_q[$];
    out_t exp_q[$];
    res_t st0, st1;
    logic st0_v = 1'b0, st1_v = 1'b0;
    int   cyc = 0, n_issue = 0, n_pop = 0, last_pop_cyc = -1, done_cyc = -1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [95:0] dp_flat();
        logic [95:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f[i*4 +: 4]      = dp_in_0_o[i];
            f[32 + i*8 +: 8] = dp_in_1_o[i];
        end
        return f;
    endfunction

    function automatic logic [95:0] in_flat();
        logic [95:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f[i*4 +: 4]      = in_0_i[i];
            f[32 + i*8 +: 8] = in_1_i[i];
        end
        return f;
    endfunction

    task automatic rand_tiles();
        for (int i = 0; i < 8; i++) begin
            in_0_i[i] = IN0'($urandom);
            in_1_i[i] = IN1'($urandom);
        end
    endtask

    // One clock cycle: inputs are already driven; observe, then advance the datapath model.
    task automatic tick();
        res_t iss;
        out_t e;
        logic iv;
        iss = '{'0, '0};
        #1;
        iv = in_valid_i && in_ready_o;
        if (iv) begin
            n_issue++;
            chk("dp_in_passthrough", 128'(dp_flat()), 128'(in_flat()));
            chk("issue_has_script", 128'(scr_q.size() != 0), 128'(1));
            if (scr_q.size() != 0) iss = scr_q.pop_front();
        end else begin
            chk("dp_in_zero_idle", 128'(dp_flat()), 128'(0));
        end
        if (out_valid_o && out_ready_i) begin
            chk("pop_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_tile", {63'(0), out_data_o[0], out_data_o[1], out_last_o}, {63'(0), e.d0, e.d1, e.last});
            end
            n_pop++;
            last_pop_cyc = cyc;
        end
        if (done_o) begin
            done_cyc = cyc;
            chk("busy_low_at_done", 128'(busy_o), 128'(0));
        end
        @(posedge clk_i);
        st1   = st0;
        st1_v = st0_v;
        st0   = iss;
        st0_v = iv;
        @(negedge clk_i);
        dp_out_i[0] = st1_v ? st1.r0 : DPW'($urandom);
        dp_out_i[1] = st1_v ? st1.r1 : DPW'($urandom);
        cyc++;
    endtask

    // Reference model: each output tile is the wrapped sum of its num_ch sign-extended results.
    task automatic plan(input int tiles, input int ch, input res_t rs[$]);
        longint s0, s1;
        out_t   o;
        for (int t = 0; t < tiles; t++) begin
            s0 = 0;
            s1 = 0;
            for (int c = 0; c < ch; c++) begin
                s0 += longint'($signed(rs[t*ch + c].r0));
                s1 += longint'($signed(rs[t*ch + c].r1));
                scr_q.push_back(rs[t*ch + c]);
            end
            o.d0   = s0[ACCW-1:0];
            o.d1   = s1[ACCW-1:0];
            o.last = (t == tiles - 1);
            exp_q.push_back(o);
        end
    endtask

    task automatic launch(input int tiles, input int ch);
        n_pop        = 0;
        done_cyc     = -1;
        last_pop_cyc = -1;
        in_valid_i   = 1'b0;
        num_tiles_i  = CNTW'(tiles);
        num_ch_i     = CNTW'(ch);
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        #1;
        chk("busy_after_start", 128'(busy_o), 128'(1));
    endtask

    task automatic finish_job(input int tiles, input int vpct, input int rpct);
        int budget;
        budget = 0;
        while (done_cyc < 0 && budget < 3000) begin
            in_valid_i  = ($urandom_range(99) < vpct);
            out_ready_i = ($urandom_range(99) < rpct);
            rand_tiles();
            tick();
            budget++;
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        chk("job_done_seen", 128'(done_cyc >= 0), 128'(1));
        chk("job_output_count", 128'(n_pop), 128'(tiles));
        chk("done_after_last_pop", 128'(done_cyc), 128'(last_pop_cyc + 1));
        chk("exp_queue_drained", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"}, 128'(busy_o), 128'(0));
        chk({tag, "_done"}, 128'(done_o), 128'(0));
        chk({tag, "_in_ready"}, 128'(in_ready_o), 128'(0));
        chk({tag, "_out_valid"}, 128'(out_valid_o), 128'(0));
        chk({tag, "_out_last"}, 128'(out_last_o), 128'(0));
        chk({tag, "_out_data"}, 128'({out_data_o[0], out_data_o[1]}), 128'(0));
        chk({tag, "_dp_in"}, 128'(dp_flat()), 128'(0));
    endtask

    vec_t vecs[5];
    res_t rs[$];
    res_t r;
    int   iss0, tiles, ch;

    initial begin
        rst_i = 1'b1; start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        num_tiles_i = '0; num_ch_i = '0;
        dp_out_i[0] = '0; dp_out_i[1] = '0;
        rand_tiles();
        @(negedge clk_i);

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            start_i = 1'($urandom); in_valid_i = 1'($urandom); out_ready_i = 1'($urandom);
            num_tiles_i = CNTW'($urandom); num_ch_i = CNTW'($urandom);
            rand_tiles();
            tick();
            #1;
            chk_cleared("reset");
        end
        rst_i = 1'b0; start_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        tick();

        // Sign extension / accumulation table: single-tile jobs with a constant result per channel
        vecs[0] = '{1, 24'hFFFFFF, 24'h000005, 32'hFFFFFFFF, 32'h00000005};
        vecs[1] = '{2, 24'hFFFFFF, 24'hFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE};
        vecs[2] = '{3, 24'h7FFFFF, 24'h800000, 32'h017FFFFD, 32'hFE800000};
        vecs[3] = '{4, 24'h000010, 24'hFFFFF0, 32'h00000040, 32'hFFFFFFC0};
        vecs[4] = '{1, 24'h000000, 24'h000001, 32'h00000000, 32'h00000001};
        for (int v = 0; v < 5; v++) begin
            for (int c = 0; c < vecs[v].ch; c++) scr_q.push_back('{vecs[v].a, vecs[v].b});
            exp_q.push_back('{vecs[v].e0, vecs[v].e1, 1'b1});
            launch(1, vecs[v].ch);
            finish_job(1, 100, 100);
        end

        // Basic accumulation: (5,7)+(-3,1) per tile
        rs.delete();
        for (int t = 0; t < 3; t++) begin
            rs.push_back('{DPW'(5), DPW'(7)});
            rs.push_back('{DPW'(-3), DPW'(1)});
        end
        plan(3, 2, rs);
        chk("basic_model_value", 128'({exp_q[0].d0, exp_q[0].d1}), 128'({32'd2, 32'd8}));
        launch(3, 2);
        finish_job(3, 100, 100);

        // Backpressure: output stalled, credits must cap issue at FIFO_DEPTH
        rs.delete();
        for (int t = 0; t < 8; t++) rs.push_back('{DPW'(100 + t), DPW'(-t)});
        plan(8, 1, rs);
        launch(8, 1);
        iss0 = n_issue;
        in_valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_tiles();
            tick();
        end
        #1;
        chk("bp_issue_count", 128'(n_issue - iss0), 128'(DEPTH));
        chk("bp_in_ready_low", 128'(in_ready_o), 128'(0));
        chk("bp_out_valid_held", 128'(out_valid_o), 128'(1));
        finish_job(8, 100, 100);

        // Zero-count jobs
        for (int z = 0; z < 2; z++) begin
            num_tiles_i = (z == 0) ? CNTW'(0) : CNTW'(2);
            num_ch_i    = (z == 0) ? CNTW'(3) : CNTW'(0);
            in_valid_i  = 1'b1;
            start_i     = 1'b1;
            tick();
            start_i = 1'b0;
            #1;
            chk("zero_done_pulse", 128'(done_o), 128'(1));
            chk("zero_busy", 128'(busy_o), 128'(0));
            chk("zero_in_ready", 128'(in_ready_o), 128'(0));
            tick();
            #1;
            chk("zero_done_one_cycle", 128'(done_o), 128'(0));
            chk("zero_in_ready_after", 128'(in_ready_o), 128'(0));
            in_valid_i = 1'b0;
        end

        // Reset mid-job after 2 of 4 tiles issued
        rs.delete();
        for (int t = 0; t < 4; t++) rs.push_back('{DPW'($urandom), DPW'($urandom)});
        plan(4, 1, rs);
        launch(4, 1);
        iss0 = n_issue;
        in_valid_i = 1'b1;
        for (int i = 0; i < 10 && (n_issue - iss0) < 2; i++) begin
            rand_tiles();
            tick();
        end
        chk("midjob_two_issued", 128'(n_issue - iss0), 128'(2));
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk_cleared("midjob_reset");
        scr_q.delete();
        exp_q.delete();
        n_pop = 0;
        out_ready_i = 1'b1;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("midjob_stale_ignored", 128'(n_pop), 128'(0));
        in_valid_i = 1'b0;
        rs.delete();
        rs.push_back('{DPW'(123), DPW'(-9)});
        plan(1, 1, rs);
        launch(1, 1);
        finish_job(1, 100, 100);

        // Randomised jobs against the reference model
        for (int j = 0; j < 8; j++) begin
            tiles = int'($urandom_range(1, 6));
            ch    = int'($urandom_range(1, 4));
            rs.delete();
            for (int n = 0; n < tiles * ch; n++) begin
                r.r0 = DPW'($urandom);
                r.r1 = DPW'($urandom);
                rs.push_back(r);
            end
            plan(tiles, ch, rs);
            launch(tiles, ch);
            finish_job(tiles, int'($urandom_range(40, 100)), int'($urandom_range(30, 100)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

endmodule

// File: doc/winograd_sched.md
# winograd_sched

Job controller for the Winograd datapath. Accepts an operand-tile stream over valid/ready and issues at most one tile per cycle into the datapath's fixed 2-cycle pipeline. Accumulates the signed datapath results over `num_ch` channel tiles per output tile and buffers finished outputs in a small FIFO. The datapath cannot stall, so the block uses credit-based issue control to guarantee that the output FIFO never overflows.

## Interface
- `IN_SIZE_0`, default 4: width of each operand-0 element.
- `IN_SIZE_1`, default 8: width of each operand-1 element.
- `DP_SIZE`, default ((IN_SIZE_1+1)*2)+6: width of each datapath result.
- `ACC_SIZE`, default 32: accumulator and output width. Must satisfy ACC_SIZE ≥ DP_SIZE.
- `FIFO_DEPTH`, default 4: output FIFO entries. Must be ≥ 2.
- `CNT_WIDTH`, default 8: width of the tile and channel counts.

Ports:
- `clk_i` in, 1: the single clock.
- `rst_i` in, 1: reset. **Synchronous, active-high.**
- `start_i` in, 1: job start pulse. Sampled only in IDLE.
- `num_tiles_i` in, CNT_WIDTH: output tiles in the job. Latched on start.
- `num_ch_i` in, CNT_WIDTH: channel tiles accumulated per output. Latched on start.
- `busy_o` out, 1: high while in RUN or DRAIN.
- `done_o` out, 1: one-cycle job-complete pulse.
- `in_valid_i` in, 1: operand tile valid.
- `in_ready_o` out, 1: ready to accept an operand tile.
- `in_0_i` in, [0:7] × IN_SIZE_0: operand-0 tile.
- `in_1_i` in, [0:7] × IN_SIZE_1: operand-1 tile.
- `dp_in_0_o` out, [0:7] × IN_SIZE_0: operand-0 tile to the datapath.
- `dp_in_1_o` out, [0:7] × IN_SIZE_1: operand-1 tile to the datapath.
- `dp_out_i` in, [0:1] × DP_SIZE: datapath results, two's complement.
- `out_valid_o` out, 1: FIFO head valid.
- `out_ready_i` in, 1: downstream ready.
- `out_data_o` out, [0:1] × ACC_SIZE: accumulated output tile.
- `out_last_o` out, 1: marks the final output tile of the job.

## Operation
- **Issue rule:** a tile issues in a cycle when `in_valid_i && in_ready_o`.
  - `dp_in_*_o` equal `in_*_i` in an issue cycle and are all-zero otherwise (combinational).
- **FSM states:** IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start_i` when both counts are non-zero. Counts are latched on this transition.
  - IDLE → DONE on `start_i` when either count is zero.
  - RUN → DRAIN on the issue of the final tile (tile num_tiles−1, channel num_ch−1).
  - DRAIN → DONE when no tiles are in flight and the FIFO is empty.
  - DONE → IDLE unconditionally. `done_o` is high only in DONE.
- **Issue counters:** `ch_cnt` and `tile_cnt` advance on each issue. `ch_cnt` wraps to 0 at num_ch−1, and `tile_cnt` increments on that wrap.
- **In-flight tracking:** a 2-stage tag shift register mirrors the datapath pipeline. Each tag holds {valid, first_ch, last_ch, last_tile}.
- **Accumulation on tag retirement:**
  - Each result is `r[k] = sext(dp_out_i[k])` to ACC_SIZE.
  - If first_ch: `acc[k] = r[k]`. Otherwise: `acc[k] += r[k]`, wrapping mod 2^ACC_SIZE.
  - If last_ch: push {acc + r, last_tile} into the FIFO. When num_ch = 1, first_ch and last_ch are both set and the pushed value is r.
- **Credit rule:** `in_ready_o = (state==RUN) && (fifo_count + inflight_last_ch < FIFO_DEPTH)`.
  - `inflight_last_ch` counts in-flight tags (0..2) with last_ch set.
  - The rule is conservative: a same-cycle pop does not add credit.
- **FIFO:**
  - `out_valid_o` = not empty. `out_data_o` and `out_last_o` reflect the head entry.
  - Pop on `out_valid_o && out_ready_i`. A simultaneous push and pop leaves the count unchanged.
  - The FIFO cannot overflow by construction; an overflow is an assertion failure.
- `start_i` outside IDLE is ignored.

## Timing
- **Reset:** `rst_i` high at a clock edge clears the FSM to IDLE, counters, tags, accumulator and FIFO.
  - Outputs during and after reset: `busy_o`, `done_o`, `in_ready_o`, `out_valid_o`, `out_last_o` = 0; `out_data_o` = 0; `dp_in_*_o` = 0.
  - Reset mid-job discards in-flight tags; later `dp_out_i` values are ignored.
- **Issue-to-result alignment:** a tile issued in cycle t has its result on `dp_out_i` in cycle t+2. The tag retires at the end of t+2.
- **Output latency:** `out_valid_o` rises in cycle t+3 for a last_ch tile issued in cycle t.
- **Throughput:** one tile per cycle while credits allow.
- **Start:** `start_i` in cycle t makes `busy_o` and `in_ready_o` (credits permitting) high from cycle t+1.
- **Zero-count job:** `done_o` pulses in cycle t+1 and `busy_o` stays 0.
- **Job end:** `done_o` pulses in the cycle after the last FIFO pop. `busy_o` falls in that same cycle.

## Test plan
- **Reset:** assert `rst_i` for 2 cycles with random inputs → all outputs 0, FSM IDLE. The bench models the datapath as a 2-cycle delay returning scripted values.
- **Basic accumulation:** num_tiles=3, num_ch=2, scripted results (5, 7) then (−3, 1) per tile pair → three outputs (2, 8), `out_last_o` only on the third; `done_o` one cycle after the third pop.
- **Backpressure:** num_tiles=8, num_ch=1, FIFO_DEPTH=4, `out_ready_i`=0 → exactly 4 issues, then `in_ready_o`=0 and `out_valid_o` held. Releasing `out_ready_i` → all 8 outputs in order, no loss or duplication.
- **Sign extension:** `dp_out_i` = all-ones, num_ch=1 → `out_data_o` = 0xFFFFFFFF. With num_ch=2 and two all-ones results → 0xFFFFFFFE.
- **Zero-count job:** start with num_tiles=0 → `done_o` pulses next cycle, `in_ready_o` never high, `busy_o`=0.
- **Reset mid-job:** `rst_i` pulsed after 2 of 4 tiles issued → outputs cleared, stale `dp_out_i` ignored. A following 1×1 job returns the correct single result.
